// File: rtl/nco_ddc_mixer_dec.sv
// Quadrature down-mixer with a power-of-two integrate-and-dump decimator.
// It multiplies real ADC samples by the NCO cos/sin pair, then integrates
// 2^k products and dumps one rounded, saturated I/Q pair per window.
module nco_ddc_mixer_dec #(
  parameter int unsigned adw  = 16,
  parameter int unsigned mpr  = 16,
  parameter int unsigned ow   = 16,
  parameter int unsigned dmax = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic [adw-1:0]        adc_data,
  input  logic                  adc_valid,
  input  logic [mpr-1:0]        nco_sin,
  input  logic [mpr-1:0]        nco_cos,
  input  logic                  nco_valid,
  input  logic [2:0]            dec_log2,
  output logic [ow-1:0]         i_out,
  output logic [ow-1:0]         q_out,
  output logic                  out_valid,
  output logic                  sat_flag
);

  localparam int unsigned PW = adw + mpr;
  localparam int unsigned AW = PW + dmax;
  localparam logic signed [AW:0] OMAX = (AW + 1)'((2 ** (ow - 1)) - 1);
  localparam logic signed [AW:0] OMIN = -OMAX - 1;

  // S1 registers
  logic           s1_valid;
  logic [adw-1:0] s1_adc;
  logic [mpr-1:0] s1_sin, s1_cos;
  logic [2:0]     s1_k;

  // S2 registers
  logic                 s2_valid;
  logic signed [PW-1:0] s2_pi, s2_pq;
  logic [2:0]           s2_k;

  // S3 integrator state
  logic signed [AW-1:0] acc_i, acc_q;
  logic [dmax-1:0]      cnt;
  logic [2:0]           k_win;
  logic                 dump;

  // The clamped decimation ratio travels with its sample so a window's k is
  // the value present when its first sample was accepted.
  logic [2:0] k_clamped;
  assign k_clamped = (32'(dec_log2) > dmax) ? 3'(dmax) : dec_log2;

  // S1: capture the inputs and the accept strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_adc   <= '0;
      s1_sin   <= '0;
      s1_cos   <= '0;
      s1_k     <= '0;
    end else if (clken) begin
      s1_valid <= adc_valid & nco_valid;
      s1_adc   <= adc_data;
      s1_sin   <= nco_sin;
      s1_cos   <= nco_cos;
      s1_k     <= k_clamped;
    end
  end

  // Full-width operands keep -(min*min) representable after negation.
  logic signed [PW-1:0] adc_x, sin_x, cos_x, mul_i, mul_s;
  assign adc_x = PW'($signed(s1_adc));
  assign sin_x = PW'($signed(s1_sin));
  assign cos_x = PW'($signed(s1_cos));
  assign mul_i = adc_x * cos_x;
  assign mul_s = adc_x * sin_x;

  // S2: register the mixer products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_pi    <= '0;
      s2_pq    <= '0;
      s2_k     <= '0;
    end else if (clken) begin
      s2_valid <= s1_valid;
      s2_pi    <= mul_i;
      s2_pq    <= -mul_s;
      s2_k     <= s1_k;
    end
  end

  // Window bookkeeping: k is latched only on the first beat of a window.
  logic [2:0]           beat_k;
  logic                 beat_last;
  logic signed [AW-1:0] base_i, base_q;
  always_comb begin
    beat_k    = (cnt == '0) ? s2_k : k_win;
    beat_last = ((32'(cnt) + 32'd1) == (32'd1 << beat_k));
    base_i    = dump ? '0 : acc_i;
    base_q    = dump ? '0 : acc_q;
  end

  // S3: integrate valid beats; a dump restarts the sum from the next product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
      k_win <= '0;
      dump  <= 1'b0;
    end else if (clken) begin
      dump <= s2_valid & beat_last;
      if (s2_valid) begin
        acc_i <= base_i + AW'(s2_pi);
        acc_q <= base_q + AW'(s2_pq);
        k_win <= beat_k;
        cnt   <= beat_last ? '0 : cnt + 1'b1;
      end else begin
        acc_i <= base_i;
        acc_q <= base_q;
      end
    end
  end

  // Round half toward +inf, scale by 2^-(mpr-1+k), clamp; MSB is the sat bit.
  function automatic logic [ow:0] round_sat(input logic signed [AW-1:0] acc,
                                            input logic [2:0] k);
    logic signed [AW:0] ext;
    logic signed [AW:0] sh;
    ext = (AW + 1)'(acc) + ((AW + 1)'(1) << (mpr - 2 + 32'(k)));
    sh  = ext >>> (mpr - 1 + 32'(k));
    if (sh > OMAX)      round_sat = {1'b1, OMAX[ow-1:0]};
    else if (sh < OMIN) round_sat = {1'b1, OMIN[ow-1:0]};
    else                round_sat = {1'b0, sh[ow-1:0]};
  endfunction

  logic [ow:0] rs_i, rs_q;
  assign rs_i = round_sat(acc_i, k_win);
  assign rs_q = round_sat(acc_q, k_win);

  // Output stage: one-cycle pulses, data held between dumps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (clken) begin
      out_valid <= dump;
      sat_flag  <= dump & (rs_i[ow] | rs_q[ow]);
      if (dump) begin
        i_out <= rs_i[ow-1:0];
        q_out <= rs_q[ow-1:0];
      end
    end else begin
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nco_ddc_mixer_dec.sv
// Scoreboard bench for nco_ddc_mixer_dec: an arithmetic window model pushes
// expected I/Q pairs at accept time; a monitor pops on each out_valid.
module tb_nco_ddc_mixer_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic [15:0] adc_data, nco_sin, nco_cos;
  logic        adc_valid, nco_valid;
  logic [2:0]  dec_log2;
  logic [15:0] i_out, q_out;
  logic        out_valid, sat_flag;

  int checks = 0;
  int errors = 0;
  int en_edges = 0;
  int pulses = 0;

  typedef struct {
    int i;
    int q;
    bit sat;
    int due;
  } exp_t;
  exp_t exp_q[$];

  // reference window state
  int     win_cnt = 0;
  int     win_k = 0;
  longint sum_i = 0, sum_q = 0;

  nco_ddc_mixer_dec #(.adw(16), .mpr(16), .ow(16), .dmax(6)) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .nco_sin(nco_sin), .nco_cos(nco_cos), .nco_valid(nco_valid),
    .dec_log2(dec_log2),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic int scale(input longint s, input int k, output bit sat);
    longint r;
    r = (s + (longint'(1) <<< (14 + k))) >>> (15 + k);
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    if (r < -32768) begin r = -32768; sat = 1'b1; end
    return int'(r);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_clear();
    win_cnt = 0;
    sum_i = 0;
    sum_q = 0;
    exp_q.delete();
  endtask

  // Reference model: integrate accepted products per window of 2^k samples
  always @(posedge clk) begin
    if (!reset && clken) begin
      en_edges++;
      if (adc_valid && nco_valid) begin
        longint a, s, c;
        exp_t e;
        bit si, sq;
        a = longint'($signed(adc_data));
        s = longint'($signed(nco_sin));
        c = longint'($signed(nco_cos));
        if (win_cnt == 0) win_k = (dec_log2 > 6) ? 6 : int'(dec_log2);
        sum_i += a * c;
        sum_q += -(a * s);
        win_cnt++;
        if (win_cnt == (1 << win_k)) begin
          e.i = scale(sum_i, win_k, si);
          e.q = scale(sum_q, win_k, sq);
          e.sat = si | sq;
          e.due = en_edges + 3;
          exp_q.push_back(e);
          win_cnt = 0;
          sum_i = 0;
          sum_q = 0;
        end
      end
    end
  end

  // Monitor: compare each presented output against the head of the queue
  always @(negedge clk) begin
    if (sat_flag && !out_valid) begin
      checks++;
      errors++;
      $display("FAIL sat_without_valid: sat_flag=1 out_valid=0");
    end
    if (out_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: i=%0d q=%0d with no pending expectation",
                 $signed(i_out), $signed(q_out));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("i_out", longint'($signed(i_out)), e.i);
        check("q_out", longint'($signed(q_out)), e.q);
        check("sat_flag", sat_flag, e.sat);
        check("latency", en_edges, e.due);
      end
    end
  end

  task automatic drive(input bit en, input bit av, input bit nv, input logic [15:0] a,
                       input logic [15:0] s, input logic [15:0] c, input logic [2:0] d);
    clken = en;
    adc_valid = av;
    nco_valid = nv;
    adc_data = a;
    nco_sin = s;
    nco_cos = c;
    dec_log2 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 16'h0, 16'h0, 16'h0, dec_log2);
  endtask

  // Async reset asserted between edges; outputs must clear immediately
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rnd16();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 16'h8000;
    if (r == 1) return 16'h7fff;
    return 16'($urandom);
  endfunction

  initial begin
    reset = 1'b0;
    clken = 1'b0;
    adc_valid = 1'b0;
    nco_valid = 1'b0;
    adc_data = '0;
    nco_sin = '0;
    nco_cos = '0;
    dec_log2 = '0;
    #2;
    pulse_reset();
    idle(2);

    // T1: DC tone on I, N=1
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 16'd16384, 16'd0, 16'd32767, 3'd0);
    // T2: tone on Q, then min*min on both rails (I saturates)
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 16'd16384, 16'd32767, 16'd0, 3'd0);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 16'h8000, 16'h8000, 16'h8000, 3'd0);
    idle(5);
    check("t2_pulses", pulses, 15);

    // T3: N=4 with products 1..4 x 2^15 -> 2.5 rounds to 3
    for (int n = 1; n <= 4; n++) drive(1, 1, 1, 16'(2 * n), 16'd0, 16'd16384, 3'd2);
    idle(5);
    check("t3_pulses", pulses, 16);
    check("t3_i_out", longint'($signed(i_out)), 3);

    // T4: switch 2->0 after the 2nd sample; window still needs 4 samples
    for (int n = 0; n < 8; n++)
      drive(1, 1, 1, 16'(100 * (n + 1)), 16'd300, 16'd12000, (n < 2) ? 3'd2 : 3'd0);
    idle(5);
    check("t4_pulses", pulses, 16 + 1 + 4);

    // T5: NCO warm-up, then accepts resume
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 16'd5000, 16'd7, 16'd9, 3'd0);
    check("t5_no_out", pulses, 21);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 16'd5000, 16'd20000, 16'd9000, 3'd0);
    idle(5);

    // T6: reset mid-window discards the partial sum
    drive(1, 1, 1, 16'd1234, 16'd2000, 16'd30000, 3'd0);
    idle(4);
    for (int i = 0; i < 2; i++) drive(1, 1, 1, 16'd7000, 16'd100, 16'd20000, 3'd2);
    pulse_reset();
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 16'd3000, 16'd1000, 16'd20000, 3'd2);
    idle(5);
    check("t6_no_early_dump", exp_q.size(), 0);
    drive(1, 1, 1, 16'd3000, 16'd1000, 16'd20000, 3'd2);
    idle(5);

    // Random phase: bubbles, clock-enable gaps, dec changes, occasional reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1200 || i == 2400) pulse_reset();
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85,
            $urandom_range(0, 99) < 90, rnd16(), rnd16(), rnd16(),
            (i % 97 < 40) ? 3'($urandom_range(0, 2)) : 3'($urandom));
    end
    idle(20);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
